// File: rtl/c2f_chunk_sink.sv
// c2f_chunk_sink: ring of byte-masked chunk buffers fed by CPU->FPGA burst
// writes; committed chunks are streamed out in order on a valid/ready port
// through a 2-entry skid buffer, then freed.
module c2f_chunk_sink #(
    parameter int CHUNK_IDX_BITS = 2,
    parameter int CHUNK_OFS_BITS = 7
) (
    input  logic                      pcieClk_in,
    input  logic                      pcieRstN_in,
    input  logic                      c2fWriteEnable_in,
    input  logic [7:0]                c2fByteMask_in,
    input  logic [CHUNK_IDX_BITS-1:0] c2fChunkIndex_in,
    input  logic [CHUNK_OFS_BITS-1:0] c2fChunkOffset_in,
    input  logic [63:0]               c2fData_in,
    input  logic                      commitValid_in,
    output logic [63:0]               outData_out,
    output logic                      outValid_out,
    input  logic                      outReady_in,
    output logic                      outLast_out,
    output logic [CHUNK_IDX_BITS:0]   wrPtr_out,
    output logic [CHUNK_IDX_BITS:0]   rdPtr_out,
    output logic                      overflow_out
);
    localparam int CIB   = CHUNK_IDX_BITS;
    localparam int COB   = CHUNK_OFS_BITS;
    localparam int AW    = CIB + COB;
    localparam int DEPTH = 1 << AW;
    localparam logic [CIB:0] NUM_CHUNKS = (CIB+1)'(1 << CIB);
    localparam logic [CIB:0] PTR_ONE    = (CIB+1)'(1);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    logic [63:0]    mem_q [DEPTH];
    logic [CIB:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, f_ptr_q, f_ptr_d;
    logic           ovf_q, ovf_d;
    state_t         state_q, state_d;
    logic [COB-1:0] ofs_q, ofs_d;
    logic           issue, space, pending, pop, full, commit_ok;
    logic [2:0]     occ;
    logic           rd_vld_q, rd_last_q;
    logic [63:0]    rd_data_q;
    logic [63:0]    buf_data_q [2];
    logic           buf_last_q [2];
    logic           wp_q, rp_q;
    logic [1:0]     cnt_q, cnt_d;

    // Byte-enabled chunk RAM; never cleared, writes are not pointer-checked.
    always_ff @(posedge pcieClk_in) begin
        for (int b = 0; b < 8; b++) begin
            if (c2fWriteEnable_in && c2fByteMask_in[b])
                mem_q[{c2fChunkIndex_in, c2fChunkOffset_in}][8*b +: 8] <= c2fData_in[8*b +: 8];
        end
    end

    // RAM read port: data sampled at issue time, lands one cycle later.
    always_ff @(posedge pcieClk_in) begin
        if (issue) rd_data_q <= mem_q[{f_ptr_q[CIB-1:0], ofs_q}];
    end

    assign pop          = outValid_out && outReady_in;
    assign full         = (wr_ptr_q - rd_ptr_q) == NUM_CHUNKS;
    assign commit_ok    = commitValid_in && !full;
    assign pending      = f_ptr_q != wr_ptr_q;
    // Slots held by buffered plus in-flight data after this cycle's pop.
    assign occ          = {1'b0, cnt_q} + 3'(rd_vld_q) - 3'(pop);
    assign space        = occ < 3'd2;
    assign outValid_out = cnt_q != 2'd0;
    assign outData_out  = buf_data_q[rp_q];
    assign outLast_out  = outValid_out && buf_last_q[rp_q];
    assign wrPtr_out    = wr_ptr_q;
    assign rdPtr_out    = rd_ptr_q;
    assign overflow_out = ovf_q;

    // Pointer bookkeeping: commits (dropped when full) and chunk frees.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q + 2'(rd_vld_q) - 2'(pop);
        if (commit_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (commitValid_in && full) ovf_d = 1'b1;
        if (pop && outLast_out) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Fetch engine next state: issue reads while the skid buffer has room;
    // IDLE issues offset 0 directly so the first beat appears two edges
    // after the commit.
    always_comb begin
        state_d = state_q;
        ofs_d   = ofs_q;
        f_ptr_d = f_ptr_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    state_d = S_FETCH;
                    issue   = space;
                end
            end
            S_FETCH: issue = space;
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            ofs_d = ofs_q + 1'b1;
            if (ofs_q == '1) begin
                f_ptr_d = f_ptr_q + PTR_ONE;
                state_d = ((f_ptr_q + PTR_ONE) != wr_ptr_q) ? S_FETCH : S_IDLE;
            end
        end
    end

    // State, pointers, read-stage flags and skid buffer registers.
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state_q   <= S_IDLE;
            ofs_q     <= '0;
            f_ptr_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            ofs_q     <= ofs_d;
            f_ptr_q   <= f_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            rd_vld_q  <= issue;
            rd_last_q <= issue && (ofs_q == '1);
            cnt_q     <= cnt_d;
            if (rd_vld_q) begin
                buf_data_q[wp_q] <= rd_data_q;
                buf_last_q[wp_q] <= rd_last_q;
                wp_q             <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
        end
    end
endmodule
